// File: rtl/inverse_reorder_buffer.sv
// Line buffer that re-interleaves a deinterleaved line (low half, then high half)
// into natural order L0 H0 L1 H1 ... ahead of the inverse-DWT synthesis filter.
module inverse_reorder_buffer #(
    parameter int DataWidth   = 16,
    parameter int MaxLineSize = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] inData,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic                 inSof,
    input  logic                 inEol,
    output logic [DataWidth-1:0] outData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 outSof,
    output logic                 outEol,
    output logic                 draining
);
    localparam int AW = $clog2(MaxLineSize);
    localparam int CW = AW + 1;

    typedef enum logic {Load, Drain} state_t;
    state_t state, stateNext;

    logic [DataWidth-1:0] mem [MaxLineSize];
    logic [DataWidth-1:0] rdData, bypassData;
    logic [CW-1:0]        wcnt, k, kNext, lineLen, lowLen, rdIdx;
    logic [AW-1:0]        rdAddr;
    logic                 sofFlag, useBypass;
    logic                 inFire, outFire, lastIn, rdEn;

    assign inFire  = inValid && inReady;
    assign outFire = outValid && outReady;
    // A line ends on eol or when the buffer fills (forced truncation).
    assign lastIn  = inFire && (inEol || (wcnt == CW'(MaxLineSize - 1)));

    always_ff @(posedge clk) begin
        if (rst) state <= Load;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            Load:  if (lastIn)            stateNext = Drain;
            Drain: if (outFire && outEol) stateNext = Load;
            default:                      stateNext = Load;
        endcase
    end

    always_comb begin
        inReady  = (state == Load);
        outValid = (state == Drain);
        draining = (state == Drain);
        outSof   = (state == Drain) && sofFlag;
        outEol   = (state == Drain) && (k == lineLen - CW'(1));
    end

    // Even beats read the low half, odd beats read the high half starting at lowLen.
    always_comb begin
        kNext = k + CW'(1);
        if (state == Load)  rdIdx = '0;
        else if (kNext[0])  rdIdx = lowLen + (kNext >> 1);
        else                rdIdx = kNext >> 1;
        rdAddr = rdIdx[AW-1:0];
        rdEn   = lastIn || (outFire && !outEol);
    end

    always_ff @(posedge clk) begin
        if (inFire) mem[wcnt[AW-1:0]] <= inData;
        if (rdEn)   rdData <= mem[rdAddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt       <= '0;
            k          <= '0;
            lineLen    <= '0;
            lowLen     <= '0;
            sofFlag    <= 1'b0;
            useBypass  <= 1'b0;
            bypassData <= '0;
        end else begin
            if (inFire) begin
                wcnt <= wcnt + CW'(1);
                if (inSof) sofFlag <= 1'b1;
            end
            if (lastIn) begin
                lineLen    <= wcnt + CW'(1);
                lowLen     <= (wcnt + CW'(2)) >> 1;
                // A one-beat line is read in the cycle it is written, so serve it from a register.
                useBypass  <= (wcnt == '0);
                bypassData <= inData;
            end
            if (outFire) begin
                sofFlag <= 1'b0;
                if (outEol) begin
                    wcnt      <= '0;
                    k         <= '0;
                    useBypass <= 1'b0;
                end else begin
                    k <= kNext;
                end
            end
        end
    end

    assign outData = useBypass ? bypassData : rdData;

endmodule
